// File: rtl/sort_stream_arbiter_if.sv
// Single AXI-Stream style beat channel (valid/ready/last/data) shared by the
// arbiter's requester inputs and its output toward the sort core.
interface sort_stream_arbiter_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic [DATA_WIDTH-1:0] tdata;

   modport master (output tvalid, output tlast, output tdata, input tready);
   modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/sort_stream_arbiter.sv
// Frame-atomic two-requester round-robin arbiter with a one-entry output register.
// Define SORT_ARB_STATS_EN to add per-requester frame counters (frame_cnt0/1).
module sort_stream_arbiter #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   sort_stream_arbiter_if.slave  s0,
   sort_stream_arbiter_if.slave  s1,
   sort_stream_arbiter_if.master m,
   output logic [1:0]            grant
`ifdef SORT_ARB_STATS_EN
   ,
   output logic [15:0]           frame_cnt0,
   output logic [15:0]           frame_cnt1
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic                  last_q, last_d;
   logic                  ovalid_q, ovalid_d;
   logic                  olast_q, olast_d;
   logic [DATA_WIDTH-1:0] odata_q, odata_d;
   logic                  out_free;
   logic                  acc0, acc1;

   // The output register can take a beat when empty or being drained this cycle.
   assign out_free  = !ovalid_q || m.tready;
   assign s0.tready = (state_q == GNT0) && out_free;
   assign s1.tready = (state_q == GNT1) && out_free;
   assign acc0      = s0.tvalid && s0.tready;
   assign acc1      = s1.tvalid && s1.tready;

   assign grant    = {state_q == GNT1, state_q == GNT0};
   assign m.tvalid = ovalid_q;
   assign m.tlast  = olast_q;
   assign m.tdata  = odata_q;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d = state_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            // On contention the requester that was not granted most recently wins.
            if (s0.tvalid && (!s1.tvalid || last_q)) begin
               state_d = GNT0;
               last_d  = 1'b0;
            end else if (s1.tvalid) begin
               state_d = GNT1;
               last_d  = 1'b1;
            end
         end
         GNT0: if (acc0 && s0.tlast) state_d = IDLE;
         GNT1: if (acc1 && s1.tlast) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ovalid_d = ovalid_q;
      olast_d  = olast_q;
      odata_d  = odata_q;
      if (acc0 || acc1) begin
         ovalid_d = 1'b1;
         olast_d  = acc1 ? s1.tlast : s0.tlast;
         odata_d  = acc1 ? s1.tdata : s0.tdata;
      end else if (ovalid_q && m.tready) begin
         ovalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: the data register is reset as well, since odata is observable and must read 0 after reset.
      if (reset) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         ovalid_q <= 1'b0;
         olast_q  <= 1'b0;
         odata_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q  <= state_d;
         last_q   <= last_d;
         ovalid_q <= ovalid_d;
         olast_q  <= olast_d;
         odata_q  <= odata_d;
      end
   end

`ifdef SORT_ARB_STATS_EN
   logic [15:0] frame_cnt0_q, frame_cnt1_q;

   // Counters wrap naturally from 16'hFFFF to 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt0_q <= 16'd0;
         frame_cnt1_q <= 16'd0;
      end else begin
         if (acc0 && s0.tlast) frame_cnt0_q <= frame_cnt0_q + 16'd1;
         if (acc1 && s1.tlast) frame_cnt1_q <= frame_cnt1_q + 16'd1;
      end
   end

   assign frame_cnt0 = frame_cnt0_q;
   assign frame_cnt1 = frame_cnt1_q;
`endif

endmodule

// File: tb/tb_sort_stream_arbiter.sv
// Directed self-checking bench for sort_stream_arbiter; outputs sampled on the falling edge.
// Frame counter checks are built only when SORT_ARB_STATS_EN is defined.
`timescale 1ns/1ps
module tb_sort_stream_arbiter;
   localparam int DW = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] grant;
   int         pass_cnt  = 0;
   int         total_cnt = 0;
   bit         mon_en    = 1'b0;

   logic [15:0] cap_data[$];
   logic        cap_last[$];
   logic [1:0]  grant_log[$];
   logic        vld_log[$];
   logic [15:0] dat_log[$];
   logic        rdy0_log[$];

   sort_stream_arbiter_if #(.DATA_WIDTH(DW)) s0_if ();
   sort_stream_arbiter_if #(.DATA_WIDTH(DW)) s1_if ();
   sort_stream_arbiter_if #(.DATA_WIDTH(DW)) m_if ();

`ifdef SORT_ARB_STATS_EN
   logic [15:0] frame_cnt0, frame_cnt1;
`endif

   sort_stream_arbiter #(.DATA_WIDTH(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .s0    (s0_if),
      .s1    (s1_if),
      .m     (m_if),
      .grant (grant)
`ifdef SORT_ARB_STATS_EN
      ,
      .frame_cnt0 (frame_cnt0),
      .frame_cnt1 (frame_cnt1)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mon_en) begin
         grant_log.push_back(grant);
         vld_log.push_back(m_if.tvalid);
         dat_log.push_back(m_if.tdata);
         rdy0_log.push_back(s0_if.tready);
         if (m_if.tvalid && m_if.tready) begin
            cap_data.push_back(m_if.tdata);
            cap_last.push_back(m_if.tlast);
         end
      end
   end

   task automatic clear_logs();
      cap_data  = {};
      cap_last  = {};
      grant_log = {};
      vld_log   = {};
      dat_log   = {};
      rdy0_log  = {};
   endtask

   task automatic set_src(input bit r, input logic v, input logic [15:0] d, input logic l);
      if (r) begin
         s1_if.tvalid = v;
         s1_if.tdata  = d;
         s1_if.tlast  = l;
      end else begin
         s0_if.tvalid = v;
         s0_if.tdata  = d;
         s0_if.tlast  = l;
      end
   endtask

   // Drives one frame; beat i carries start + i*step, tlast on the final beat.
   task automatic send_frame(input bit r, input int n, input logic [15:0] start,
                             input int step, output bit ok);
      int   i      = 0;
      int   budget = 0;
      logic acc;
      ok = 1'b1;
      while (i < n) begin
         set_src(r, 1'b1, start + 16'(i * step), i == n - 1);
         @(negedge clk);
         acc = r ? (s1_if.tvalid && s1_if.tready) : (s0_if.tvalid && s0_if.tready);
         @(posedge clk);
         #1;
         if (acc) i++;
         budget++;
         if (budget > 500) begin
            ok = 1'b0;
            break;
         end
      end
      set_src(r, 1'b0, 16'h0000, 1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      set_src(1'b0, 1'b0, 16'h0000, 1'b0);
      set_src(1'b1, 1'b0, 16'h0000, 1'b0);
      m_if.tready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      set_src(1'b0, 1'b1, 16'h1111, 1'b0);
      set_src(1'b1, 1'b1, 16'h2222, 1'b0);
      m_if.tready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total_cnt++;
      if (m_if.tvalid !== 1'b0) $display("FAIL reset_ovalid: got %b want 0", m_if.tvalid);
      else pass_cnt++;
      total_cnt++;
      if (m_if.tlast !== 1'b0) $display("FAIL reset_olast: got %b want 0", m_if.tlast);
      else pass_cnt++;
      total_cnt++;
      if (m_if.tdata !== 16'h0000) $display("FAIL reset_odata: got %h want 0000", m_if.tdata);
      else pass_cnt++;
      total_cnt++;
      if (s0_if.tready !== 1'b0) $display("FAIL reset_s0_tready: got %b want 0", s0_if.tready);
      else pass_cnt++;
      total_cnt++;
      if (s1_if.tready !== 1'b0) $display("FAIL reset_s1_tready: got %b want 0", s1_if.tready);
      else pass_cnt++;
      total_cnt++;
      if (grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", grant);
      else pass_cnt++;
      @(posedge clk);
      #1;
      set_src(1'b0, 1'b0, 16'h0000, 1'b0);
      set_src(1'b1, 1'b0, 16'h0000, 1'b0);
      m_if.tready = 1'b1;
      reset = 1'b0;
   endtask

   task automatic test_single();
      logic [1:0]  exp_g [7];
      logic        exp_v [7];
      logic [15:0] exp_d [4];
      logic        exp_l [4];
      bit          ok;
      exp_g = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
      exp_v = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      exp_d = '{16'h0004, 16'h0003, 16'h0002, 16'h0001};
      exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
      m_if.tready = 1'b1;
      clear_logs();
      mon_en = 1'b1;
      send_frame(1'b0, 4, 16'h0004, -1, ok);
      repeat (2) @(posedge clk);
      #1;
      mon_en = 1'b0;
      total_cnt++;
      if (!ok) $display("FAIL single_timeout: got stalled frame want 4 beats accepted");
      else pass_cnt++;
      for (int k = 0; k < 7; k++) begin
         total_cnt++;
         if (k >= grant_log.size() || grant_log[k] !== exp_g[k] || vld_log[k] !== exp_v[k])
            $display("FAIL single_cycle[%0d]: got grant %b ovalid %b want grant %b ovalid %b",
                     k, grant_log[k], vld_log[k], exp_g[k], exp_v[k]);
         else pass_cnt++;
      end
      total_cnt++;
      if (cap_data.size() != 4) $display("FAIL single_count: got %0d want 4", cap_data.size());
      else pass_cnt++;
      for (int k = 0; k < 4 && k < cap_data.size(); k++) begin
         total_cnt++;
         if (cap_data[k] !== exp_d[k] || cap_last[k] !== exp_l[k])
            $display("FAIL single_beat[%0d]: got %h/%b want %h/%b",
                     k, cap_data[k], cap_last[k], exp_d[k], exp_l[k]);
         else pass_cnt++;
      end
   endtask

   task automatic test_contention();
      logic [1:0]  exp_g [9];
      logic [15:0] exp_d [11];
      logic        exp_l [11];
      bit          ok0, ok1, ok2, ok3;
      exp_g = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00};
      exp_d = '{16'h0A01, 16'h0A02, 16'h0A03, 16'h0B01, 16'h0B02, 16'h0B03,
                16'h0A11, 16'h0B11, 16'h0A21, 16'h0B31, 16'h0A31};
      exp_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      do_reset();
      clear_logs();
      mon_en = 1'b1;
      fork
         send_frame(1'b0, 3, 16'h0A01, 1, ok0);
         send_frame(1'b1, 3, 16'h0B01, 1, ok1);
      join
      repeat (2) @(posedge clk);
      #1;
      // last points at requester 1 here, so requester 0 must win.
      fork
         send_frame(1'b0, 1, 16'h0A11, 1, ok2);
         send_frame(1'b1, 1, 16'h0B11, 1, ok3);
      join
      repeat (2) @(posedge clk);
      #1;
      send_frame(1'b0, 1, 16'h0A21, 1, ok0);
      repeat (2) @(posedge clk);
      #1;
      fork
         send_frame(1'b0, 1, 16'h0A31, 1, ok2);
         send_frame(1'b1, 1, 16'h0B31, 1, ok3);
      join
      repeat (2) @(posedge clk);
      #1;
      mon_en = 1'b0;
      total_cnt++;
      if (!(ok0 && ok1 && ok2 && ok3)) $display("FAIL contention_timeout: got stalled frame want all accepted");
      else pass_cnt++;
      for (int k = 0; k < 9; k++) begin
         total_cnt++;
         if (k >= grant_log.size() || grant_log[k] !== exp_g[k])
            $display("FAIL contention_grant[%0d]: got %b want %b", k, grant_log[k], exp_g[k]);
         else pass_cnt++;
      end
      total_cnt++;
      if (cap_data.size() != 11) $display("FAIL contention_count: got %0d want 11", cap_data.size());
      else pass_cnt++;
      for (int k = 0; k < 11 && k < cap_data.size(); k++) begin
         total_cnt++;
         if (cap_data[k] !== exp_d[k] || cap_last[k] !== exp_l[k])
            $display("FAIL contention_beat[%0d]: got %h/%b want %h/%b",
                     k, cap_data[k], cap_last[k], exp_d[k], exp_l[k]);
         else pass_cnt++;
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      m_if.tready = 1'b1;
      clear_logs();
      mon_en = 1'b1;
      fork
         send_frame(1'b0, 5, 16'h0C01, 1, ok);
         for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            m_if.tready = !(k == 3 || k == 4);
         end
      join
      repeat (2) @(posedge clk);
      #1;
      mon_en = 1'b0;
      total_cnt++;
      if (!ok) $display("FAIL bp_timeout: got stalled frame want 5 beats accepted");
      else pass_cnt++;
      total_cnt++;
      if (cap_data.size() != 5) $display("FAIL bp_count: got %0d want 5", cap_data.size());
      else pass_cnt++;
      for (int k = 0; k < 5 && k < cap_data.size(); k++) begin
         total_cnt++;
         if (cap_data[k] !== 16'h0C01 + 16'(k) || cap_last[k] !== (k == 4))
            $display("FAIL bp_beat[%0d]: got %h/%b want %h/%b",
                     k, cap_data[k], cap_last[k], 16'h0C01 + 16'(k), k == 4);
         else pass_cnt++;
      end
      for (int k = 3; k <= 4; k++) begin
         total_cnt++;
         if (k >= vld_log.size() || vld_log[k] !== 1'b1 || dat_log[k] !== 16'h0C02 || rdy0_log[k] !== 1'b0)
            $display("FAIL bp_hold[%0d]: got ovalid %b odata %h s0_tready %b want 1 0c02 0",
                     k, vld_log[k], dat_log[k], rdy0_log[k]);
         else pass_cnt++;
      end
      total_cnt++;
      if (rdy0_log.size() < 6 || rdy0_log[5] !== 1'b1)
         $display("FAIL bp_resume: got s0_tready %b want 1", rdy0_log[5]);
      else pass_cnt++;
   endtask

   task automatic test_one_beat();
      logic [1:0] exp_g [7];
      bit         ok;
      bit         all_ok = 1'b1;
      exp_g = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
      m_if.tready = 1'b1;
      clear_logs();
      mon_en = 1'b1;
      for (int f = 0; f < 3; f++) begin
         send_frame(1'b1, 1, 16'h0D01 + 16'(f), 1, ok);
         all_ok = all_ok && ok;
      end
      repeat (2) @(posedge clk);
      #1;
      mon_en = 1'b0;
      total_cnt++;
      if (!all_ok) $display("FAIL onebeat_timeout: got stalled frame want 3 frames accepted");
      else pass_cnt++;
      for (int k = 0; k < 7; k++) begin
         total_cnt++;
         if (k >= grant_log.size() || grant_log[k] !== exp_g[k])
            $display("FAIL onebeat_grant[%0d]: got %b want %b", k, grant_log[k], exp_g[k]);
         else pass_cnt++;
      end
      total_cnt++;
      if (cap_data.size() != 3) $display("FAIL onebeat_count: got %0d want 3", cap_data.size());
      else pass_cnt++;
      for (int k = 0; k < 3 && k < cap_data.size(); k++) begin
         total_cnt++;
         if (cap_data[k] !== 16'h0D01 + 16'(k) || cap_last[k] !== 1'b1)
            $display("FAIL onebeat_beat[%0d]: got %h/%b want %h/1",
                     k, cap_data[k], cap_last[k], 16'h0D01 + 16'(k));
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] exp_d [5];
      logic        exp_l [5];
      int          accepted = 0;
      int          budget   = 0;
      logic        acc;
      bit          ok0, ok1, ok2;
      exp_d = '{16'h0E21, 16'h0F21, 16'h0F01, 16'h0F02, 16'h0F03};
      exp_l = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      m_if.tready = 1'b1;
      set_src(1'b0, 1'b1, 16'h0E01, 1'b0);
      while (accepted < 2 && budget < 50) begin
         @(negedge clk);
         acc = s0_if.tvalid && s0_if.tready;
         @(posedge clk);
         #1;
         budget++;
         if (acc) begin
            accepted++;
            s0_if.tdata = 16'h0E01 + 16'(accepted);
         end
      end
      total_cnt++;
      if (accepted != 2) $display("FAIL rstmid_accept: got %0d beats want 2", accepted);
      else pass_cnt++;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      total_cnt++;
      if (m_if.tvalid !== 1'b0 || m_if.tlast !== 1'b0 || m_if.tdata !== 16'h0000)
         $display("FAIL rstmid_out: got %b/%b/%h want 0/0/0000", m_if.tvalid, m_if.tlast, m_if.tdata);
      else pass_cnt++;
      total_cnt++;
      if (grant !== 2'b00 || s0_if.tready !== 1'b0 || s1_if.tready !== 1'b0)
         $display("FAIL rstmid_ctrl: got grant %b treadys %b%b want 00 00",
                  grant, s1_if.tready, s0_if.tready);
      else pass_cnt++;
      @(posedge clk);
      #1;
      reset = 1'b0;
      set_src(1'b0, 1'b0, 16'h0000, 1'b0);
      clear_logs();
      mon_en = 1'b1;
      fork
         send_frame(1'b0, 1, 16'h0E21, 1, ok0);
         send_frame(1'b1, 1, 16'h0F21, 1, ok1);
      join
      send_frame(1'b1, 3, 16'h0F01, 1, ok2);
      repeat (2) @(posedge clk);
      #1;
      mon_en = 1'b0;
      total_cnt++;
      if (!(ok0 && ok1 && ok2)) $display("FAIL rstmid_timeout: got stalled frame want all accepted");
      else pass_cnt++;
      total_cnt++;
      if (cap_data.size() != 5) $display("FAIL rstmid_count: got %0d want 5", cap_data.size());
      else pass_cnt++;
      for (int k = 0; k < 5 && k < cap_data.size(); k++) begin
         total_cnt++;
         if (cap_data[k] !== exp_d[k] || cap_last[k] !== exp_l[k])
            $display("FAIL rstmid_beat[%0d]: got %h/%b want %h/%b",
                     k, cap_data[k], cap_last[k], exp_d[k], exp_l[k]);
         else pass_cnt++;
      end
   endtask

`ifdef SORT_ARB_STATS_EN
   task automatic test_stats();
      bit ok;
      bit all_ok = 1'b1;
      int frames = 0;
      int budget = 0;
      do_reset();
      for (int f = 0; f < 3; f++) begin
         send_frame(1'b0, 2, 16'h5000 + 16'(f * 16), 1, ok);
         all_ok = all_ok && ok;
      end
      for (int f = 0; f < 2; f++) begin
         send_frame(1'b1, 1, 16'h6000 + 16'(f), 1, ok);
         all_ok = all_ok && ok;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      total_cnt++;
      if (!all_ok || frame_cnt0 !== 16'd3 || frame_cnt1 !== 16'd2)
         $display("FAIL stats_count: got %0d/%0d want 3/2", frame_cnt0, frame_cnt1);
      else pass_cnt++;
      @(posedge clk);
      #1;
      set_src(1'b0, 1'b1, 16'h7000, 1'b1);
      while (frames < 65533 && budget < 140000) begin
         @(negedge clk);
         if (s0_if.tvalid && s0_if.tready) frames++;
         @(posedge clk);
         #1;
         budget++;
      end
      set_src(1'b0, 1'b0, 16'h0000, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      total_cnt++;
      if (frames != 65533 || frame_cnt0 !== 16'd0 || frame_cnt1 !== 16'd2)
         $display("FAIL stats_wrap: got %0d/%0d after %0d frames want 0/2", frame_cnt0, frame_cnt1, frames);
      else pass_cnt++;
      @(posedge clk);
      #1;
   endtask
`endif

   initial begin
      reset = 1'b1;
      set_src(1'b0, 1'b0, 16'h0000, 1'b0);
      set_src(1'b1, 1'b0, 16'h0000, 1'b0);
      m_if.tready = 1'b0;
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_one_beat();
      test_reset_mid();
`ifdef SORT_ARB_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
